// File: rtl/nibble_serial_add_ctrl_if.sv
// Request/response handshake bundle for nibble_serial_add_ctrl.
// The master drives operands and accepts results; the slave is the controller.
interface nibble_serial_add_ctrl_if #(
   parameter int WIDTH = 16
);
   logic             req_valid;
   logic             req_ready;
   logic [WIDTH-1:0] req_a;
   logic [WIDTH-1:0] req_b;
   logic             req_cin;
   logic             req_sub;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_sum;
   logic             rsp_cout;

   modport master (
      output req_valid, req_a, req_b, req_cin, req_sub, rsp_ready,
      input  req_ready, rsp_valid, rsp_sum, rsp_cout
   );

   modport slave (
      input  req_valid, req_a, req_b, req_cin, req_sub, rsp_ready,
      output req_ready, rsp_valid, rsp_sum, rsp_cout
   );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: runs a WIDTH-bit add through one shared 4-bit adder
// slice, one nibble per cycle, LSB first, with the inter-nibble carry registered.
// Optional feature macro: SERIAL_SUB_EN (enables req_sub = subtract; cout = borrow).
//
// state | meaning
// IDLE  | ready for a request, adder inputs parked at 0
// RUN   | driving nibble r_idx into the adder, capturing its sum/carry each edge
// DONE  | result held on rsp_*, waiting for rsp_ready
module nibble_serial_add_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   nibble_serial_add_ctrl_if.slave bus,
   output logic [3:0]              add_a,
   output logic [3:0]              add_b,
   output logic                    add_cin,
   input  logic [3:0]              add_s,
   input  logic                    add_cout,
   output logic                    busy
);
   localparam int NIB = WIDTH / 4;
   localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [IW-1:0] LAST = IW'(NIB - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           r_state;
   logic [IW-1:0]    r_idx;
   logic             r_carry;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_c0;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_rsp_valid;
`ifdef SERIAL_SUB_EN
   logic             r_sub;
`endif

   logic [WIDTH-1:0] w_b_in;
   logic             w_c0_in;
   logic [WIDTH-1:0] w_a_sh;
   logic [WIDTH-1:0] w_b_sh;

   // Operand B and carry-in as they are latched on accept (inverted for subtract).
   always_comb begin
`ifdef SERIAL_SUB_EN
      w_b_in  = bus.req_sub ? ~bus.req_b : bus.req_b;
      w_c0_in = bus.req_sub ? 1'b1 : bus.req_cin;
`else
      w_b_in  = bus.req_b;
      w_c0_in = bus.req_cin;
`endif
   end

   assign w_a_sh = r_a >> {r_idx, 2'b00};
   assign w_b_sh = r_b >> {r_idx, 2'b00};

   // Adder slice inputs: current nibble while running, parked at zero otherwise.
   always_comb begin
      add_a   = 4'd0;
      add_b   = 4'd0;
      add_cin = 1'b0;
      if (r_state == RUN) begin
         add_a   = w_a_sh[3:0];
         add_b   = w_b_sh[3:0];
         add_cin = (r_idx == '0) ? r_c0 : r_carry;
      end
   end

   // Sequencer: accept, step through nibbles, hold result until handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_idx       <= '0;
         r_carry     <= 1'b0;
         r_a         <= '0;
         r_b         <= '0;
         r_c0        <= 1'b0;
         r_sum       <= '0;
         r_cout      <= 1'b0;
         r_rsp_valid <= 1'b0;
`ifdef SERIAL_SUB_EN
         r_sub       <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.req_valid) begin
                  r_a     <= bus.req_a;
                  r_b     <= w_b_in;
                  r_c0    <= w_c0_in;
                  r_idx   <= '0;
                  r_state <= RUN;
`ifdef SERIAL_SUB_EN
                  r_sub   <= bus.req_sub;
`endif
               end
            end
            RUN: begin
               for (int n = 0; n < NIB; n++) begin
                  if (r_idx == IW'(n)) r_sum[4*n +: 4] <= add_s;
               end
               r_carry <= add_cout;
               if (r_idx == LAST) begin
                  r_state     <= DONE;
                  r_rsp_valid <= 1'b1;
`ifdef SERIAL_SUB_EN
                  // Subtract reports borrow, which is the inverted final carry.
                  r_cout      <= add_cout ^ r_sub;
`else
                  r_cout      <= add_cout;
`endif
               end else begin
                  r_idx <= r_idx + IW'(1);
               end
            end
            DONE: begin
               if (bus.rsp_ready) begin
                  r_state     <= IDLE;
                  r_rsp_valid <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.req_ready = (r_state == IDLE);
   assign busy          = (r_state != IDLE);
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_sum   = r_sum;
   assign bus.rsp_cout  = r_cout;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl (WIDTH=16) with a behavioural 4-bit adder slice.
module tb_nibble_serial_add_ctrl;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] add_a, add_b, add_s;
   logic       add_cin, add_cout, busy;
   int         n_cmp = 0;
   int         n_fail = 0;
   int         cycles;

   nibble_serial_add_ctrl_if #(.WIDTH(16)) bus ();

   nibble_serial_add_ctrl #(.WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
      .add_s(add_s), .add_cout(add_cout), .busy(busy)
   );

   // The shared adder_4bit slice.
   assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present a request, return #1 after the accepting edge with req_valid dropped.
   task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                           input logic cin, input logic sub);
      @(posedge clk); #1;
      bus.req_a = a; bus.req_b = b; bus.req_cin = cin; bus.req_sub = sub;
      bus.req_valid = 1'b1;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
   endtask

   // Count edges until rsp_valid, then check latency and result.
   task automatic wait_rsp(input string tag, input logic [15:0] exp_sum, input logic exp_cout);
      cycles = 0;
      while (bus.rsp_valid !== 1'b1 && cycles < 20) begin
         @(posedge clk); #1;
         cycles++;
      end
      check({tag, "_lat"}, cycles, 4);
      check({tag, "_sum"}, bus.rsp_sum, exp_sum);
      check({tag, "_cout"}, bus.rsp_cout, exp_cout);
   endtask

   task automatic finish_rsp(input string tag);
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
      check({tag, "_vld_drop"}, bus.rsp_valid, 0);
      check({tag, "_rdy_back"}, bus.req_ready, 1);
   endtask

   initial begin
      bus.req_valid = 1'b0; bus.req_a = '0; bus.req_b = '0;
      bus.req_cin = 1'b0; bus.req_sub = 1'b0; bus.rsp_ready = 1'b0;
      #1;
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_req_ready", bus.req_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_sum", bus.rsp_sum, 0);
      check("rst_add_a", add_a, 0);
      #22 rst_n = 1'b1;

      // 1. basic add with carries between nibbles
      start_op(16'h1234, 16'h0FFF, 1'b0, 1'b0);
      check("t1_busy", busy, 1);
      check("t1_req_ready", bus.req_ready, 0);
      wait_rsp("t1", 16'h2233, 1'b0);
      finish_rsp("t1");

      // 2. full wrap and carry-in rippling across three nibbles
      start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      wait_rsp("t2a", 16'h0000, 1'b1);
      finish_rsp("t2a");
      start_op(16'h0FFF, 16'h0000, 1'b1, 1'b0);
      wait_rsp("t2b", 16'h1000, 1'b0);
      finish_rsp("t2b");

      // 3. back-pressure in DONE with request noise
      start_op(16'h0102, 16'h0304, 1'b0, 1'b0);
      wait_rsp("t3", 16'h0406, 1'b0);
      for (int i = 0; i < 6; i++) begin
         bus.req_valid = i[0];
         bus.req_a = 16'hAAAA; bus.req_b = 16'h5555;
         @(posedge clk); #1;
         check("t3_hold_vld", bus.rsp_valid, 1);
         check("t3_hold_sum", bus.rsp_sum, 16'h0406);
         check("t3_hold_rdy", bus.req_ready, 0);
      end
      bus.req_valid = 1'b0;
      finish_rsp("t3");
      @(posedge clk); #1;
      check("t3_no_capture", busy, 0);

      // 4. request held high through RUN is ignored until IDLE
      start_op(16'h1111, 16'h2222, 1'b0, 1'b0);
      bus.req_a = 16'h00FF; bus.req_b = 16'h0101; bus.req_cin = 1'b0;
      bus.req_valid = 1'b1;
      wait_rsp("t4a", 16'h3333, 1'b0);
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
      check("t4_idle_after_hs", bus.req_ready, 1);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      check("t4_second_accept", busy, 1);
      wait_rsp("t4b", 16'h0200, 1'b0);
      finish_rsp("t4b");

      // 5. asynchronous reset mid-RUN
      start_op(16'hABCD, 16'h0000, 1'b0, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("t5_nib2_a", add_a, 4'hB);
      #2 rst_n = 1'b0;
      #1;
      check("t5_rst_busy", busy, 0);
      check("t5_rst_rdy", bus.req_ready, 1);
      check("t5_rst_vld", bus.rsp_valid, 0);
      check("t5_rst_sum", bus.rsp_sum, 0);
      check("t5_rst_add_a", add_a, 0);
      #3 rst_n = 1'b1;
      start_op(16'h0003, 16'h0004, 1'b0, 1'b0);
      wait_rsp("t5", 16'h0007, 1'b0);
      finish_rsp("t5");

      // 6. subtract (or add when the feature is compiled out)
      start_op(16'h0005, 16'h0007, 1'b0, 1'b1);
`ifdef SERIAL_SUB_EN
      wait_rsp("t6a", 16'hFFFE, 1'b1);
`else
      wait_rsp("t6a", 16'h000C, 1'b0);
`endif
      finish_rsp("t6a");
      start_op(16'h0007, 16'h0005, 1'b0, 1'b1);
`ifdef SERIAL_SUB_EN
      wait_rsp("t6b", 16'h0002, 1'b0);
`else
      wait_rsp("t6b", 16'h000C, 1'b0);
`endif
      finish_rsp("t6b");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
